// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shifter: operation and state encodings
// plus a small parameter-checking helper.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // True when v is a positive power of two.
    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift stage: moves the working value by k positions
// (0..STEP) according to the latched operation.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   data,
    input  op_e                op,
    input  logic [SHAMT_W-1:0] k,
    input  logic               sign,
    output logic [WIDTH-1:0]   result
);

    logic [2*WIDTH-1:0] ext;

    // SRA shifts a sign-extended double-width word so the fill comes from the
    // captured sign, not the current MSB; ROL uses a duplicated word so the
    // upper half carries the wrapped-around bits.
    always_comb begin
        ext    = '0;
        result = data;
        case (op)
            OP_SLL: result = data << k;
            OP_SRL: result = data >> k;
            OP_SRA: begin
                ext    = {{WIDTH{sign}}, data} >> k;
                result = ext[WIDTH-1:0];
            end
            OP_ROL: begin
                ext    = {data, data} << k;
                result = ext[2*WIDTH-1:WIDTH];
            end
            default: result = data;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle variable shifter with start/done handshake. Shifts at most STEP
// positions per clock; the result register holds its value until the next done.
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int STEP    = 4,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   y
);

    generate
        if (STEP < 1 || STEP > WIDTH || WIDTH < 4 || !is_pow2(WIDTH)) begin : g_bad_param
            $error("seq_shifter: WIDTH must be a power of two >= 4 and STEP in 1..WIDTH");
        end
    endgenerate

    // Largest per-cycle step expressible on SHAMT_W bits. cnt never exceeds
    // WIDTH-1, so clamping STEP=WIDTH to WIDTH-1 leaves min(STEP, cnt) unchanged.
    localparam logic [SHAMT_W-1:0] STEP_K =
        (STEP >= WIDTH) ? SHAMT_W'(WIDTH - 1) : SHAMT_W'(STEP);

    state_e             state_reg;
    op_e                op_reg;
    logic [WIDTH-1:0]   data_reg;
    logic [SHAMT_W-1:0] cnt_reg;
    logic               sign_reg;
    logic [WIDTH-1:0]   y_reg;
    logic               done_reg;

    logic [SHAMT_W-1:0] k_next;
    logic [WIDTH-1:0]   data_next;

    // Step size for this cycle: whatever remains, capped at STEP.
    always_comb begin
        k_next = (cnt_reg > STEP_K) ? STEP_K : cnt_reg;
    end

    shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_step (
        .data   (data_reg),
        .op     (op_reg),
        .k      (k_next),
        .sign   (sign_reg),
        .result (data_next)
    );

    // Control FSM with datapath registers; done is a registered one-cycle pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_SLL;
            data_reg  <= '0;
            cnt_reg   <= '0;
            sign_reg  <= 1'b0;
            y_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        data_reg  <= a;
                        cnt_reg   <= shamt;
                        op_reg    <= op_e'(op);
                        sign_reg  <= a[WIDTH-1];
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_reg != '0) begin
                        data_reg <= data_next;
                        cnt_reg  <= cnt_reg - k_next;
                    end else begin
                        y_reg     <= data_reg;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_reg == ST_SHIFT);
    assign done = done_reg;
    assign y    = y_reg;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: one instance with STEP=4 and one with STEP=1
// share the same stimulus; each has its own latency model.
module tb_seq_shifter;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [W-1:0] a;
    logic [3:0]  shamt;

    logic        busy4, done4, busy1, done1;
    logic [W-1:0] y4, y1;

    logic        busy_v [2];
    logic        done_v [2];
    logic [W-1:0] y_v   [2];

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(16), .STEP(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .shamt(shamt),
        .busy(busy4), .done(done4), .y(y4)
    );

    seq_shifter #(.WIDTH(16), .STEP(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .shamt(shamt),
        .busy(busy1), .done(done1), .y(y1)
    );

    assign busy_v[0] = busy4;
    assign done_v[0] = done4;
    assign y_v[0]    = y4;
    assign busy_v[1] = busy1;
    assign done_v[1] = done1;
    assign y_v[1]    = y1;

    typedef struct {
        int          d;
        logic [15:0] y;
        int          done_edge;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          free_edge [2];
    int          busy_lo   [2];
    int          busy_hi   [2];
    logic [15:0] held_y    [2];
    int          checks = 0;
    int          fails  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int step_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    // Reference result from the operation definitions.
    function automatic logic [15:0] ref_y(input logic [1:0] o, input logic [15:0] v, input int s);
        logic signed [15:0] sv;
        logic [15:0]        r;
        sv = v;
        case (o)
            2'd0:    r = v << s;
            2'd1:    r = v >> s;
            2'd2:    r = sv >>> s;
            default: r = (s == 0) ? v : ((v << s) | (v >> (16 - s)));
        endcase
        return r;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, expv);
        end
    endtask

    // Model the upcoming rising edge, then advance to the next falling edge.
    task automatic step();
        for (int d = 0; d < 2; d++) begin
            if (reset_n && start && (cyc + 1 >= free_edge[d])) begin
                int n, e0;
                exp_t e;
                n  = (int'(shamt) + step_of(d) - 1) / step_of(d);
                e0 = cyc + 1;
                e.d = d;
                e.y = ref_y(op, a, int'(shamt));
                e.done_edge = e0 + n + 1;
                sb.push_back(e);
                busy_lo[d]   = e0;
                busy_hi[d]   = e0 + n;
                free_edge[d] = e0 + n + 2;
                $display("accept dut%0d op=%0d a=%h shamt=%0d edge=%0d exp_y=%h", d, op, a, shamt, e0, e.y);
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        while ((cyc + 1 < free_edge[0]) || (cyc + 1 < free_edge[1])) step();
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] av, input logic [3:0] s);
        op = o; a = av; shamt = s; start = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
    endtask

    task automatic model_reset();
        sb.delete();
        for (int d = 0; d < 2; d++) begin
            free_edge[d] = 0;
            busy_lo[d]   = 1;
            busy_hi[d]   = 0;
            held_y[d]    = '0;
        end
    endtask

    // Monitor: samples away from the clock edge and compares against the scoreboard.
    always @(posedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            int idx;
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
                if (idx < 0 && sb[i].d == d) idx = i;
            end
            check("busy", d, 32'(busy_v[d]), 32'((cyc >= busy_lo[d]) && (cyc <= busy_hi[d])));
            check("done_busy_excl", d, 32'(done_v[d] & busy_v[d]), 32'd0);
            if (done_v[d]) begin
                if (idx < 0) begin
                    check("unexpected_done", d, 32'd1, 32'd0);
                end else begin
                    check("y", d, 32'(y_v[d]), 32'(sb[idx].y));
                    check("done_edge", d, 32'(cyc), 32'(sb[idx].done_edge));
                    $display("done dut%0d edge=%0d y=%h exp=%h", d, cyc, y_v[d], sb[idx].y);
                    held_y[d] = sb[idx].y;
                    sb.delete(idx);
                end
            end else begin
                if (idx >= 0 && sb[idx].done_edge <= cyc) begin
                    check("missing_done", d, 32'(cyc), 32'(sb[idx].done_edge - 1));
                    sb.delete(idx);
                end
                check("y_held", d, 32'(y_v[d]), 32'(held_y[d]));
            end
        end
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; shamt = '0;
        model_reset();
        step(); step();
        reset_n = 1'b1;
        step();

        // Directed cases
        run_op(2'd0, 16'h0001, 4'd2);   // SLL -> 0004
        run_op(2'd2, 16'h8000, 4'd15);  // SRA -> FFFF
        run_op(2'd1, 16'h8000, 4'd15);  // SRL -> 0001
        run_op(2'd3, 16'h8001, 4'd4);   // ROL -> 0018
        run_op(2'd3, 16'hBEEF, 4'd0);   // shamt 0 -> BEEF

        // Start while busy is ignored
        op = 2'd0; a = 16'h00F1; shamt = 4'd8; start = 1'b1;
        step();
        op = 2'd1; a = 16'h1234; shamt = 4'd3;
        step();
        start = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of a shift
        op = 2'd1; a = 16'hA5A5; shamt = 4'd15; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        reset_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_busy", d, 32'(busy_v[d]), 32'd0);
            check("reset_done", d, 32'(done_v[d]), 32'd0);
            check("reset_y", d, 32'(y_v[d]), 32'd0);
        end
        @(negedge clk);
        step();
        reset_n = 1'b1;
        step(); step();
        run_op(2'd0, 16'h0003, 4'd3);   // -> 0018

        // Start held high across done: SLL 1 by 1, then SLL 1 by 8
        op = 2'd0; a = 16'h0001; shamt = 4'd1; start = 1'b1;
        step();
        shamt = 4'd8;
        step(); step(); step();
        start = 1'b0;
        wait_idle();

        // Randomised traffic, including back-to-back and ignored starts
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 1) == 1);
            op    = 2'($urandom_range(0, 3));
            a     = 16'($urandom);
            shamt = 4'($urandom_range(0, 15));
            step();
        end
        start = 1'b0;
        for (int i = 0; i < 25; i++) step();

        check("scoreboard_empty", 0, 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
